// File: rtl/v2f_alu_arbiter_if.sv
// v2f_alu_arbiter_if: requester-side and shared-unit-side signals of the
// v2f ALU arbiter. The "slave" modport is the arbiter's view; "master" is the
// surrounding environment (requesters plus the shared arithmetic unit).
interface v2f_alu_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
);
  // requester request channel
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*OP_W-1:0]  req_op;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;

  // shared unit issue/result
  logic                   alu_valid;
  logic [OP_W-1:0]        alu_op;
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [WIDTH-1:0]       alu_y;

  // requester response channel
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_y;
  logic                   rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_y,
    input  req_ready, alu_valid, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_y, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_y,
    output req_ready, alu_valid, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_y, rsp_err
  );
endinterface

// File: rtl/v2f_alu_arbiter.sv
// v2f_alu_arbiter: round-robin arbiter/sequencer time-sharing one v2f
// arithmetic unit of fixed latency LAT among N_REQ requesters. Issues at most
// one op per cycle, tracks requester IDs through the unit, and routes each
// result back as a one-hot pulse LAT+1 cycles after the handshake.
// Optional feature macro: V2F_ARB_DIV0_GUARD_EN (div/mod by zero is
// suppressed at the unit and answered with rsp_y=0, rsp_err=1).
module v2f_alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int LAT   = 1
) (
  input logic             clk,
  input logic             rst_n,
  v2f_alu_arbiter_if.slave bus
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MOD  = OP_W'(4);

  // round-robin state and combinational grant
  logic [ID_W-1:0]  rr_ptr;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [N_REQ-1:0] grant_vec;

  // operands of the granted requester
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_div0;

  // issue register stage (aligned with alu_valid)
  logic             alu_valid_q;
  logic [OP_W-1:0]  alu_op_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             iss_v;
  logic [ID_W-1:0]  iss_id;
  logic             iss_z;

  // ID tracking pipeline, LAT stages behind the issue stage
  logic             trk_v  [LAT];
  logic [ID_W-1:0]  trk_id [LAT];
  logic             trk_z  [LAT];

  // response path
  logic             out_v;
  logic [ID_W-1:0]  out_id;
  logic             out_z;
  logic [N_REQ-1:0] rsp_v_c;
  logic [WIDTH-1:0] rsp_y_c;
  logic [WIDTH-1:0] rsp_y_hold;
  logic             rsp_err_c;

  // First valid requester at or after rr_ptr, wrapping; nothing while in reset
  always_comb begin : arb_c
    int unsigned cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % N_REQ;
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(cand);
      end
    end
    if (!rst_n) begin
      grant_any = 1'b0;
    end
    grant_vec = '0;
    if (grant_any) begin
      grant_vec[grant_id] = 1'b1;
    end
  end

  assign bus.req_ready = grant_vec;

  // Mux out the granted requester's opcode/operands and flag divide-by-zero
  always_comb begin
    sel_op = bus.req_op[grant_id*OP_W +: OP_W];
    sel_a  = bus.req_a[grant_id*WIDTH +: WIDTH];
    sel_b  = bus.req_b[grant_id*WIDTH +: WIDTH];
`ifdef V2F_ARB_DIV0_GUARD_EN
    sel_div0 = ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b == '0);
`else
    sel_div0 = 1'b0;
`endif
  end

  // Pointer moves to one past the granted index; holds with no grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  // Issue stage: capture the granted op; operand registers hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      iss_v       <= 1'b0;
      iss_id      <= '0;
      iss_z       <= 1'b0;
    end else begin
      // a guarded div0 still occupies the slot (iss_v) but never strobes the unit
      alu_valid_q <= grant_any & ~sel_div0;
      iss_v       <= grant_any;
      iss_z       <= grant_any & sel_div0;
      if (grant_any) begin
        alu_op_q <= sel_op;
        alu_a_q  <= sel_a;
        alu_b_q  <= sel_b;
        iss_id   <= grant_id;
      end
    end
  end

  assign bus.alu_valid = alu_valid_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;

  // Carry {valid, id, div0} alongside the unit's LAT-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        trk_v[k]  <= 1'b0;
        trk_id[k] <= '0;
        trk_z[k]  <= 1'b0;
      end
    end else begin
      trk_v[0]  <= iss_v;
      trk_id[0] <= iss_id;
      trk_z[0]  <= iss_z;
      for (int unsigned k = 1; k < LAT; k++) begin
        trk_v[k]  <= trk_v[k-1];
        trk_id[k] <= trk_id[k-1];
        trk_z[k]  <= trk_z[k-1];
      end
    end
  end

  assign out_v  = trk_v[LAT-1];
  assign out_id = trk_id[LAT-1];
  assign out_z  = trk_z[LAT-1];

  // Response is combinational from the last tracking stage so alu_y is
  // forwarded in the same cycle it is valid; rsp_y otherwise shows the
  // last delivered value from rsp_y_hold.
  always_comb begin
    rsp_v_c = '0;
    if (out_v) begin
      rsp_v_c[out_id] = 1'b1;
    end
    if (out_v) begin
      rsp_y_c = out_z ? '0 : bus.alu_y;
    end else begin
      rsp_y_c = rsp_y_hold;
    end
`ifdef V2F_ARB_DIV0_GUARD_EN
    rsp_err_c = out_v & out_z;
`else
    rsp_err_c = 1'b0;
`endif
  end

  // Remember the last delivered result for the idle-hold behaviour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_y_hold <= '0;
    end else if (out_v) begin
      rsp_y_hold <= rsp_y_c;
    end
  end

  assign bus.rsp_valid = rsp_v_c;
  assign bus.rsp_y     = rsp_y_c;
  assign bus.rsp_err   = rsp_err_c;

endmodule

// File: tb/tb_v2f_alu_arbiter.sv
// tb_v2f_alu_arbiter: drives two arbiters (LAT=1 and LAT=3) with identical
// requests; each has a behavioural shared unit. Expected responses are queued
// at handshake time and compared when due.
module tb_v2f_alu_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N*OW-1:0] req_op;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;

  v2f_alu_arbiter_if #(.N_REQ(N), .WIDTH(W), .OP_W(OW)) if1 ();
  v2f_alu_arbiter_if #(.N_REQ(N), .WIDTH(W), .OP_W(OW)) if3 ();

  assign if1.req_valid = req_valid;
  assign if1.req_op    = req_op;
  assign if1.req_a     = req_a;
  assign if1.req_b     = req_b;
  assign if3.req_valid = req_valid;
  assign if3.req_op    = req_op;
  assign if3.req_a     = req_a;
  assign if3.req_b     = req_b;

  v2f_alu_arbiter #(.N_REQ(N), .WIDTH(W), .OP_W(OW), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  v2f_alu_arbiter #(.N_REQ(N), .WIDTH(W), .OP_W(OW), .LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3));

  // behavioural shared unit
  function automatic logic [W-1:0] unit(input logic [OW-1:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 0) ? '0 : a / b;
      4'd4:    return (b == 0) ? '0 : a % b;
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd7:    return a ^ b;
      4'd8:    return a << b[4:0];
      4'd9:    return a >> b[4:0];
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  logic [W-1:0] u1;
  logic [W-1:0] u3 [3];
  always @(posedge clk) begin
    u1    <= unit(if1.alu_op, if1.alu_a, if1.alu_b);
    u3[0] <= unit(if3.alu_op, if3.alu_a, if3.alu_b);
    u3[1] <= u3[0];
    u3[2] <= u3[1];
  end
  assign if1.alu_y = u1;
  assign if3.alu_y = u3[2];

  typedef struct {
    int           due;
    logic [N-1:0] rv;
    logic [W-1:0] y;
    logic         err;
  } exp_t;

  exp_t sb1[$];
  exp_t sb3[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ptr = 0;

  logic          ea_v;
  logic [OW-1:0] ea_op;
  logic [W-1:0]  ea_a;
  logic [W-1:0]  ea_b;
  bit            ea_known;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic chk_rsp(input int which, input logic [N-1:0] rv,
                         input logic [W-1:0] y, input logic err);
    exp_t e;
    bit   due;
    due = 1'b0;
    if (which == 1) begin
      if (sb1.size() > 0 && sb1[0].due == cyc) begin due = 1'b1; e = sb1.pop_front(); end
    end else begin
      if (sb3.size() > 0 && sb3[0].due == cyc) begin due = 1'b1; e = sb3.pop_front(); end
    end
    if (due) begin
      chk($sformatf("rsp_valid_L%0d", which), rv, e.rv);
      chk($sformatf("rsp_y_L%0d", which), y, e.y);
      chk($sformatf("rsp_err_L%0d", which), err, e.err);
    end else begin
      chk($sformatf("rsp_idle_L%0d", which), rv, '0);
    end
  endtask

  // one cycle: check current outputs, log any handshake, advance to next negedge
  task automatic tick();
    int            g;
    logic [N-1:0]  eg;
    logic [OW-1:0] op;
    logic [W-1:0]  a, b;
    logic          z;
    logic          nv;
    #1;
    g = -1;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready_L1", if1.req_ready, eg);
    chk("req_ready_L3", if3.req_ready, eg);
    chk("alu_valid_L1", if1.alu_valid, ea_v);
    chk("alu_valid_L3", if3.alu_valid, ea_v);
    if (ea_known) begin
      chk("alu_op", if1.alu_op, ea_op);
      chk("alu_a", if1.alu_a, ea_a);
      chk("alu_b", if3.alu_b, ea_b);
    end
    chk_rsp(1, if1.rsp_valid, if1.rsp_y, if1.rsp_err);
    chk_rsp(3, if3.rsp_valid, if3.rsp_y, if3.rsp_err);
    nv = 1'b0;
    op = '0; a = '0; b = '0; z = 1'b0;
    if (g >= 0) begin
      op = req_op[g*OW +: OW];
      a  = req_a[g*W +: W];
      b  = req_b[g*W +: W];
`ifdef V2F_ARB_DIV0_GUARD_EN
      z = ((op == 4'd3) || (op == 4'd4)) && (b == 0);
`endif
      sb1.push_back('{due: cyc + 2, rv: eg, y: z ? '0 : unit(op, a, b), err: z});
      sb3.push_back('{due: cyc + 4, rv: eg, y: z ? '0 : unit(op, a, b), err: z});
      nv = ~z;
      ptr = (g + 1) % N;
    end
    @(posedge clk);
    ea_v = nv;
    if (g >= 0) begin
      if (z) ea_known = 1'b0;
      else begin ea_known = 1'b1; ea_op = op; ea_a = a; ea_b = b; end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    sb1.delete();
    sb3.delete();
    ptr = 0;
    ea_v = 1'b0; ea_op = '0; ea_a = '0; ea_b = '0; ea_known = 1'b1;
    #1;
    chk("rst_rsp_y_L1", if1.rsp_y, '0);
    chk("rst_rsp_y_L3", if3.rsp_y, '0);
    chk("rst_rsp_err_L1", if1.rsp_err, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [OW-1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[i*OW +: OW] = op;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
  endtask

  initial begin
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    ea_v = 1'b0; ea_op = '0; ea_a = '0; ea_b = '0; ea_known = 1'b1;
    @(negedge clk);

    // 1: reset then 10 idle cycles, all outputs zero
    do_reset();
    chk("idle_rsp_y", if1.rsp_y, '0);
    ticks(10);
    chk("idle_alu_op", if3.alu_op, '0);

    // 3: all requesters valid for 8 cycles -> grants 0,1,2,3,0,1,2,3
    set_req(0, 4'd0, 32'd100, 32'd3);
    set_req(1, 4'd1, 32'd101, 32'd4);
    set_req(2, 4'd2, 32'd102, 32'd5);
    set_req(3, 4'd5, 32'd103, 32'd6);
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] want;
      want = '0;
      want[i % N] = 1'b1;
      #1;
      chk("rr_order", if1.req_ready, want);
      tick();
      chk("sustained_alu_valid", if1.alu_valid, 1'b1);
    end
    req_valid = '0;
    ticks(5);

    // 2: req 0 add 5+7
    set_req(0, 4'd0, 32'd5, 32'd7);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("add_alu_valid", if1.alu_valid, 1'b1);
    chk("add_alu_a", if1.alu_a, 32'd5);
    chk("add_alu_b", if1.alu_b, 32'd7);
    tick();
    chk("add_rsp_valid", if1.rsp_valid, 4'b0001);
    chk("add_rsp_y", if1.rsp_y, 32'd12);
    ticks(4);
    chk("hold_rsp_y", if3.rsp_y, 32'd12);

    // 4: back-to-back from req 2,1,2: sub, mul, xor
    set_req(2, 4'd1, 32'd9, 32'd4);
    req_valid = 4'b0100;
    tick();
    set_req(1, 4'd2, 32'd3, 32'd6);
    req_valid = 4'b0010;
    tick();
    set_req(2, 4'd7, 32'd5, 32'd3);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    chk("b2b_rsp_id2", if3.rsp_valid, 4'b0100);
    chk("b2b_rsp_y5", if3.rsp_y, 32'd5);
    ticks(6);

    // 5: reset with three ops in flight; next grant goes to lowest valid
    set_req(0, 4'd6, 32'hF0, 32'h0F);
    set_req(1, 4'd8, 32'd1, 32'd4);
    set_req(3, 4'd0, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b1011;
    ticks(3);
    req_valid = '0;
    do_reset();
    req_valid = 4'b1010;
    #1;
    chk("post_rst_grant", if1.req_ready, 4'b0010);
    tick();
    req_valid = '0;
    ticks(6);

    // 6: req 1 divide by zero, then a mixed burst
    set_req(1, 4'd3, 32'd10, 32'd0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
`ifdef V2F_ARB_DIV0_GUARD_EN
    chk("div0_alu_valid", if1.alu_valid, 1'b0);
`else
    chk("div0_alu_valid", if1.alu_valid, 1'b1);
    chk("div0_alu_b", if1.alu_b, '0);
`endif
    tick();
`ifdef V2F_ARB_DIV0_GUARD_EN
    chk("div0_rsp_err", if1.rsp_err, 1'b1);
`else
    chk("div0_rsp_err", if1.rsp_err, 1'b0);
`endif
    chk("div0_rsp_valid", if1.rsp_valid, 4'b0010);
    set_req(0, 4'd3, 32'd20, 32'd3);
    set_req(1, 4'd12, 32'h1234, 32'd0);
    set_req(2, 4'd8, 32'd1, 32'd31);
    set_req(3, 4'd4, 32'd7, 32'd0);
    req_valid = 4'hF;
    ticks(4);
    set_req(0, 4'd9, 32'h8000_0000, 32'd4);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    ticks(8);

    chk("sb1_drained", 64'(sb1.size()), 64'd0);
    chk("sb3_drained", 64'(sb3.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
